// File: rtl/lifetime_pkg.sv
// lifetime_pkg: shared types and helpers for the muon-lifetime serial readout
package lifetime_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] OVF_MAX = 8'd255;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte buffer with registered full/empty flags
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign wp_n = wp + {{AW{1'b0}}, push};
  assign rp_n = rp + {{AW{1'b0}}, pop};
  assign rd_data = mem[rp[AW-1:0]];
  // flags are precomputed from next pointers so they come straight from flops
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      full <= (wp_n ^ rp_n) == {1'b1, {AW{1'b0}}};
      empty <= wp_n == rp_n;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/serial_event_tx.sv
// serial_event_tx: buffers lifetime words and sends each as a UART 8N1 frame
module serial_event_tx
  import lifetime_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       sendbusy,
  output logic       tx,
  output logic       tx_active,
  output logic [7:0] overflows
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n, rd_data;
  logic tx_n, rd_en, empty, wrap;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(send),
    .wr_data(data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .full(sendbusy),
    .empty(empty)
  );
  assign wrap = cnt == LAST;
  assign tx_active = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = wrap ? 16'd0 : cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    tx_n = tx;
    rd_en = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (!empty) begin
          rd_en = 1'b1;
          shift_n = rd_data;
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START: if (wrap) begin
        bit_idx_n = 3'd0;
        tx_n = shift[0];
        state_n = DATA;
      end
      DATA: if (wrap) begin
        bit_idx_n = bit_idx + 3'd1;
        tx_n = (bit_idx == 3'd7) ? 1'b1 : shift[bit_idx + 3'd1];
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (wrap) begin
        // chain straight into the next start bit when more bytes are queued
        rd_en = !empty;
        shift_n = empty ? shift : rd_data;
        tx_n = empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift <= 8'd0;
      tx <= 1'b1;
      overflows <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      tx <= tx_n;
      if (send && sendbusy && overflows != OVF_MAX) overflows <= overflows + 8'd1;
    end
  end
endmodule

// File: tb/tb_serial_event_tx.sv
// tb_serial_event_tx: random and directed stimulus against a queue-based line model
module tb_serial_event_tx;
  localparam int CPB = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic send = 1'b0;
  logic [7:0] data = 8'd0;
  logic sendbusy, tx, tx_active;
  logic [7:0] overflows;
  int n_chk = 0;
  int n_pass = 0;
  int t = 0;
  logic [7:0] q[$];
  int next_free = 0;
  int fs = -100000;
  logic [7:0] fb = 8'd0;
  int ovf = 0;
  serial_event_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .send(send),
    .data(data),
    .sendbusy(sendbusy),
    .tx(tx),
    .tx_active(tx_active),
    .overflows(overflows)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, got, exp);
  endtask
  // one clock: drive inputs, advance the model by one edge, then compare
  task automatic cycle(input bit r, input bit s, input logic [7:0] d);
    int pre, idx, ph;
    bit act, etx;
    reset = r;
    send = s;
    data = d;
    @(posedge clk);
    t++;
    if (r) begin
      q.delete();
      ovf = 0;
      fs = -100000;
      next_free = 0;
    end else begin
      pre = q.size();
      if (t >= next_free && pre > 0) begin
        fb = q.pop_front();
        fs = t;
        next_free = t + FRAME;
      end
      if (s) begin
        if (pre == DEPTH) ovf = (ovf == 255) ? 255 : ovf + 1;
        else q.push_back(d);
      end
    end
    #1;
    ph = t - fs;
    act = ph < FRAME;
    idx = ph / CPB;
    etx = !act ? 1'b1 : (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : fb[idx-1];
    chk("tx", int'(tx), int'(etx));
    chk("tx_active", int'(tx_active), int'(act));
    chk("sendbusy", int'(sendbusy), int'(q.size() == DEPTH));
    chk("overflows", int'(overflows), ovf);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'd0);
    idle(4);
    cycle(1'b0, 1'b1, 8'h35);
    idle(110);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 8'(i));
    idle(420);
    for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 8'(i));
    idle(520);
    chk("ovf_after_six", int'(overflows), 1);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 8'($urandom));
    chk("ovf_saturated", int'(overflows), 255);
    idle(520);
    cycle(1'b0, 1'b1, 8'hA6);
    idle(45);
    cycle(1'b1, 1'b0, 8'd0);
    chk("tx_after_reset", int'(tx), 1);
    idle(150);
    cycle(1'b0, 1'b1, 8'h5C);
    idle(110);
    for (int i = 0; i < 5000; i++) cycle(1'b0, $urandom_range(999) < 7, 8'($urandom));
    idle(500);
    chk("ovf_stream", int'(overflows), ovf);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
